// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-controller signals between the pipeline datapath and the
// central pipeline controller. The datapath side is the master, the controller
// is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int INDEX = 5,
    parameter int CNT_W = 16
);
    // Hazard-detection inputs from the pipeline stages
    logic [INDEX-1:0] id_rs1_in;
    logic [INDEX-1:0] id_rs2_in;
    logic             id_uses_rs1_in;
    logic             id_uses_rs2_in;
    logic [INDEX-1:0] ex_rs1_in;
    logic [INDEX-1:0] ex_rs2_in;
    logic [INDEX-1:0] ex_rd_in;
    logic             ex_mem_read_in;
    logic             branch_taken_in;
    logic [INDEX-1:0] mem_rd_in;
    logic             mem_reg_write_in;
    logic             mem_access_in;
    logic [INDEX-1:0] wb_rd_in;
    logic             wb_reg_write_in;
    logic             dmem_ack_in;

    // Control outputs toward the pipeline and the data memory
    logic             dmem_req_out;
    logic             pc_en_out;
    logic             ifid_en_out;
    logic             ifid_flush_out;
    logic             idex_en_out;
    logic             idex_flush_out;
    logic             exmem_en_out;
    logic             memwb_bubble_out;
    logic [1:0]       forward_a_out;
    logic [1:0]       forward_b_out;
    logic             dmem_err_out;
    logic [CNT_W-1:0] stall_cnt_out;

    modport master (
        output id_rs1_in, id_rs2_in, id_uses_rs1_in, id_uses_rs2_in,
        output ex_rs1_in, ex_rs2_in, ex_rd_in, ex_mem_read_in, branch_taken_in,
        output mem_rd_in, mem_reg_write_in, mem_access_in,
        output wb_rd_in, wb_reg_write_in, dmem_ack_in,
        input  dmem_req_out, pc_en_out, ifid_en_out, ifid_flush_out,
        input  idex_en_out, idex_flush_out, exmem_en_out, memwb_bubble_out,
        input  forward_a_out, forward_b_out, dmem_err_out, stall_cnt_out
    );

    modport slave (
        input  id_rs1_in, id_rs2_in, id_uses_rs1_in, id_uses_rs2_in,
        input  ex_rs1_in, ex_rs2_in, ex_rd_in, ex_mem_read_in, branch_taken_in,
        input  mem_rd_in, mem_reg_write_in, mem_access_in,
        input  wb_rd_in, wb_reg_write_in, dmem_ack_in,
        output dmem_req_out, pc_en_out, ifid_en_out, ifid_flush_out,
        output idex_en_out, idex_flush_out, exmem_en_out, memwb_bubble_out,
        output forward_a_out, forward_b_out, dmem_err_out, stall_cnt_out
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage core: stage enables/flushes,
// load-use and taken-branch handling, EX forwarding selects, and a
// request/ack FSM that freezes the pipe while the data memory is busy.
module pipe_hazard_ctrl #(
    parameter int INDEX   = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_idle;
    logic w_wait;
    logic w_memstall;
    logic w_timeout;
    logic w_load_use;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_ifid_flush;
    logic w_idex_en;
    logic w_idex_flush;
    logic w_exmem_en;
    logic w_memwb_bubble;

    // Forward select for one EX operand; MEM beats WB and x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [INDEX-1:0] rs,
        input logic [INDEX-1:0] mem_rd,
        input logic             mem_wr,
        input logic [INDEX-1:0] wb_rd,
        input logic             wb_wr
    );
        logic [1:0] sel;
        if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Decode memory-handshake conditions and the load-use hazard.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_wait     = (r_state == ST_WAIT);
        w_memstall = (w_idle && bus.mem_access_in && !bus.dmem_ack_in) ||
                     (w_wait && !bus.dmem_ack_in && (r_wait_cnt != WAIT_LAST));
        w_timeout  = w_wait && !bus.dmem_ack_in && (r_wait_cnt == WAIT_LAST);
        w_load_use = bus.ex_mem_read_in && (bus.ex_rd_in != '0) &&
                     ((bus.id_uses_rs1_in && (bus.id_rs1_in == bus.ex_rd_in)) ||
                      (bus.id_uses_rs2_in && (bus.id_rs2_in == bus.ex_rd_in)));
    end

    // Stage enables/flushes: memory stall freezes everything, then branch
    // squash, then load-use bubble. The timeout cycle releases the stall but
    // still drops the failed access into MEM/WB as a bubble.
    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_en      = 1'b1;
        w_idex_flush   = 1'b0;
        w_exmem_en     = 1'b1;
        w_memwb_bubble = w_timeout;
        if (w_memstall) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (bus.branch_taken_in) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else begin
            w_pc_en = 1'b1;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.dmem_req_out     = (w_idle && bus.mem_access_in) || w_wait;
        bus.pc_en_out        = w_pc_en;
        bus.ifid_en_out      = w_ifid_en;
        bus.ifid_flush_out   = w_ifid_flush;
        bus.idex_en_out      = w_idex_en;
        bus.idex_flush_out   = w_idex_flush;
        bus.exmem_en_out     = w_exmem_en;
        bus.memwb_bubble_out = w_memwb_bubble;
        bus.dmem_err_out     = w_timeout;
        bus.stall_cnt_out    = r_stall_cnt;
        bus.forward_a_out    = fwd_sel(bus.ex_rs1_in, bus.mem_rd_in, bus.mem_reg_write_in,
                                       bus.wb_rd_in, bus.wb_reg_write_in);
        bus.forward_b_out    = fwd_sel(bus.ex_rs2_in, bus.mem_rd_in, bus.mem_reg_write_in,
                                       bus.wb_rd_in, bus.wb_reg_write_in);
    end

    // Memory request FSM with bounded wait.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_access_in && !bus.dmem_ack_in) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.dmem_ack_in || (r_wait_cnt == WAIT_LAST)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change on the falling edge,
// outputs are checked 1 time unit later, state advances on the rising edge.
module tb_pipe_hazard_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_in = ~clk_in;

    pipe_hazard_ctrl_if #(.INDEX(5), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.INDEX(5), .CNT_W(16), .TIMEOUT(8)) u_dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_rs1_in = 5'd0;        bus.id_rs2_in = 5'd0;
        bus.id_uses_rs1_in = 1'b0;   bus.id_uses_rs2_in = 1'b0;
        bus.ex_rs1_in = 5'd0;        bus.ex_rs2_in = 5'd0;
        bus.ex_rd_in = 5'd0;         bus.ex_mem_read_in = 1'b0;
        bus.branch_taken_in = 1'b0;
        bus.mem_rd_in = 5'd0;        bus.mem_reg_write_in = 1'b0;
        bus.mem_access_in = 1'b0;
        bus.wb_rd_in = 5'd0;         bus.wb_reg_write_in = 1'b0;
        bus.dmem_ack_in = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_in = 1'b0;
        #2;
        // Reset state
        chk("rst_stall_cnt", 32'(bus.stall_cnt_out), 32'd0);
        chk("rst_req", 32'(bus.dmem_req_out), 32'd0);
        chk("rst_err", 32'(bus.dmem_err_out), 32'd0);
        chk("rst_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("rst_bubble", 32'(bus.memwb_bubble_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Load-use on rs1
        @(negedge clk_in);
        bus.ex_mem_read_in = 1'b1; bus.ex_rd_in = 5'd5;
        bus.id_uses_rs1_in = 1'b1; bus.id_rs1_in = 5'd5;
        #1;
        chk("lu_pc_en", 32'(bus.pc_en_out), 32'd0);
        chk("lu_ifid_en", 32'(bus.ifid_en_out), 32'd0);
        chk("lu_idex_flush", 32'(bus.idex_flush_out), 32'd1);
        chk("lu_exmem_en", 32'(bus.exmem_en_out), 32'd1);
        chk("lu_ifid_flush", 32'(bus.ifid_flush_out), 32'd0);
        @(negedge clk_in);
        bus.ex_mem_read_in = 1'b0;
        #1;
        chk("lu_next_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("lu_next_ifid_en", 32'(bus.ifid_en_out), 32'd1);
        chk("lu_next_idex_flush", 32'(bus.idex_flush_out), 32'd0);
        chk("lu_stall_cnt", 32'(bus.stall_cnt_out), 32'd1);

        // Load-use with taken branch: branch wins
        @(negedge clk_in);
        bus.ex_mem_read_in = 1'b1; bus.branch_taken_in = 1'b1;
        #1;
        chk("br_ifid_flush", 32'(bus.ifid_flush_out), 32'd1);
        chk("br_idex_flush", 32'(bus.idex_flush_out), 32'd1);
        chk("br_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("br_ifid_en", 32'(bus.ifid_en_out), 32'd1);
        @(negedge clk_in);
        bus.branch_taken_in = 1'b0;
        // Load into x0 never causes a hazard
        bus.ex_rd_in = 5'd0; bus.id_rs1_in = 5'd0;
        #1;
        chk("br_stall_cnt", 32'(bus.stall_cnt_out), 32'd1);
        chk("x0_pc_en", 32'(bus.pc_en_out), 32'd1);

        // Load-use on rs2
        @(negedge clk_in);
        bus.id_uses_rs1_in = 1'b0; bus.id_uses_rs2_in = 1'b1;
        bus.id_rs2_in = 5'd7; bus.ex_rd_in = 5'd7;
        #1;
        chk("lu2_pc_en", 32'(bus.pc_en_out), 32'd0);
        @(negedge clk_in);
        clear_inputs();
        #1;
        chk("lu2_stall_cnt", 32'(bus.stall_cnt_out), 32'd2);

        // Memory access acked on the third cycle
        bus.mem_access_in = 1'b1;
        #1;
        chk("ma_c1_req", 32'(bus.dmem_req_out), 32'd1);
        chk("ma_c1_pc_en", 32'(bus.pc_en_out), 32'd0);
        chk("ma_c1_exmem_en", 32'(bus.exmem_en_out), 32'd0);
        chk("ma_c1_bubble", 32'(bus.memwb_bubble_out), 32'd1);
        @(negedge clk_in);
        #1;
        chk("ma_c2_req", 32'(bus.dmem_req_out), 32'd1);
        chk("ma_c2_idex_en", 32'(bus.idex_en_out), 32'd0);
        chk("ma_c2_bubble", 32'(bus.memwb_bubble_out), 32'd1);
        @(negedge clk_in);
        bus.dmem_ack_in = 1'b1;
        #1;
        chk("ma_c3_req", 32'(bus.dmem_req_out), 32'd1);
        chk("ma_c3_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("ma_c3_idex_en", 32'(bus.idex_en_out), 32'd1);
        chk("ma_c3_bubble", 32'(bus.memwb_bubble_out), 32'd0);
        chk("ma_c3_err", 32'(bus.dmem_err_out), 32'd0);
        @(negedge clk_in);
        bus.mem_access_in = 1'b0; bus.dmem_ack_in = 1'b0;
        #1;
        chk("ma_done_req", 32'(bus.dmem_req_out), 32'd0);
        chk("ma_stall_cnt", 32'(bus.stall_cnt_out), 32'd4);

        // Memory timeout: 8 stall cycles, then release with error pulse
        @(negedge clk_in);
        bus.mem_access_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to_stall%0d_pc_en", i), 32'(bus.pc_en_out), 32'd0);
            chk($sformatf("to_stall%0d_err", i), 32'(bus.dmem_err_out), 32'd0);
            @(negedge clk_in);
        end
        #1;
        chk("to_rel_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("to_rel_exmem_en", 32'(bus.exmem_en_out), 32'd1);
        chk("to_rel_bubble", 32'(bus.memwb_bubble_out), 32'd1);
        chk("to_rel_err", 32'(bus.dmem_err_out), 32'd1);
        chk("to_rel_req", 32'(bus.dmem_req_out), 32'd1);
        @(negedge clk_in);
        bus.mem_access_in = 1'b0;
        #1;
        chk("to_after_err", 32'(bus.dmem_err_out), 32'd0);
        chk("to_after_req", 32'(bus.dmem_req_out), 32'd0);
        chk("to_after_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("to_stall_cnt", 32'(bus.stall_cnt_out), 32'd12);

        // Forwarding selects
        bus.mem_rd_in = 5'd3; bus.mem_reg_write_in = 1'b1;
        bus.wb_rd_in = 5'd3;  bus.wb_reg_write_in = 1'b1;
        bus.ex_rs1_in = 5'd3; bus.ex_rs2_in = 5'd3;
        #1;
        chk("fw_mem_a", 32'(bus.forward_a_out), 32'd2);
        chk("fw_mem_b", 32'(bus.forward_b_out), 32'd2);
        bus.mem_rd_in = 5'd0;
        #1;
        chk("fw_wb_a", 32'(bus.forward_a_out), 32'd1);
        chk("fw_wb_b", 32'(bus.forward_b_out), 32'd1);
        bus.mem_rd_in = 5'd3; bus.mem_reg_write_in = 1'b0; bus.ex_rs2_in = 5'd4;
        #1;
        chk("fw_nowr_a", 32'(bus.forward_a_out), 32'd1);
        chk("fw_nomatch_b", 32'(bus.forward_b_out), 32'd0);
        bus.mem_reg_write_in = 1'b1;
        bus.mem_rd_in = 5'd0; bus.wb_rd_in = 5'd0;
        bus.ex_rs1_in = 5'd0; bus.ex_rs2_in = 5'd0;
        #1;
        chk("fw_x0_a", 32'(bus.forward_a_out), 32'd0);
        chk("fw_x0_b", 32'(bus.forward_b_out), 32'd0);

        // Reset during WAIT
        @(negedge clk_in);
        clear_inputs();
        bus.mem_access_in = 1'b1;
        @(negedge clk_in);
        #1;
        chk("rw_pre_stall_cnt", 32'(bus.stall_cnt_out), 32'd13);
        rst_in = 1'b0;
        #1;
        chk("rw_rst_req", 32'(bus.dmem_req_out), 32'd1);
        chk("rw_rst_stall_cnt", 32'(bus.stall_cnt_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        bus.mem_access_in = 1'b0;
        #1;
        chk("rw_req", 32'(bus.dmem_req_out), 32'd0);
        chk("rw_pc_en", 32'(bus.pc_en_out), 32'd1);
        chk("rw_ifid_en", 32'(bus.ifid_en_out), 32'd1);
        chk("rw_idex_en", 32'(bus.idex_en_out), 32'd1);
        chk("rw_exmem_en", 32'(bus.exmem_en_out), 32'd1);
        chk("rw_bubble", 32'(bus.memwb_bubble_out), 32'd0);
        @(negedge clk_in);
        #1;
        chk("rw_stall_cnt", 32'(bus.stall_cnt_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
